// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the scoreboarded register file.
//   REGFILE_DATA_W   : default register data width
//   REGFILE_NUM_REGS : default register count
//   REGFILE_ADDR_W   : address width matching the default register count
//   reg_addr_t       : register address at the default configuration
//   reg_data_t       : register data word at the default configuration
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 8;
  localparam int REGFILE_NUM_REGS = 8;
  localparam int REGFILE_ADDR_W   = $clog2(REGFILE_NUM_REGS);

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/sb_tracker.sv
// -----------------------------------------------------------------------------
// sb_tracker
// Per-register busy-bit scoreboard with a running count of busy registers.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, clears every busy bit
//   i_set_en   in   reserve request (already qualified by the parent)
//   i_set_idx  in   register to mark busy
//   i_clr_en   in   completion (write) request (already qualified)
//   i_clr_idx  in   register to mark free
//   o_busy     out  registered busy vector, one bit per register
//   o_cnt      out  registered number of set bits in o_busy
// A set and a clear to the same register in one cycle leaves the bit set:
// the new producer owns the register.
// -----------------------------------------------------------------------------
module sb_tracker #(
  parameter int NUM_REGS = 8,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_set_en,
  input  logic [IDX_W-1:0]    i_set_idx,
  input  logic                i_clr_en,
  input  logic [IDX_W-1:0]    i_clr_idx,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [IDX_W:0]      o_cnt
);

  localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [IDX_W:0]      r_cnt;
  logic [IDX_W:0]      w_cnt_nxt;
  logic                w_inc;
  logic                w_dec;

  // Next busy vector: set has priority over clear on the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_set_en && (i_set_idx == IDX_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if (i_clr_en && (i_clr_idx == IDX_W'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
  end

  // Count only real transitions so a repeated reserve or a write to a free
  // register never moves the counter; this keeps it in [0, NUM_REGS].
  always_comb begin
    w_inc = i_set_en & ~r_busy[i_set_idx];
    w_dec = i_clr_en & r_busy[i_clr_idx] &
            ~(i_set_en & (i_set_idx == i_clr_idx));
    case ({w_inc, w_dec})
      2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
      2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_busy = r_busy;
  assign o_cnt  = r_cnt;

endmodule : sb_tracker

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Two-read / one-write register file with a busy-bit scoreboard used by the
// control unit to reserve destinations and detect read-after-write hazards.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (all state and outputs 0)
//   opA, opB   in   read addresses
//   write      in   write enable; wR / dataIn give address and data
//   rsv        in   reserve request for register rsvR
//   operand_a  out  read data port A (combinational, optional bypass)
//   operand_b  out  read data port B
//   busy_a     out  register opA has an outstanding reservation
//   busy_b     out  register opB has an outstanding reservation
//   busy_cnt   out  number of busy registers (registered)
//   hazard     out  busy_a | busy_b
// -----------------------------------------------------------------------------
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = REGFILE_DATA_W,
  parameter int  NUM_REGS = REGFILE_NUM_REGS,
  parameter bit  ZERO_REG = 1'b0,
  parameter bit  BYPASS   = 1'b1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] opA,
  input  logic [ADDR_W-1:0] opB,
  input  logic              write,
  input  logic [ADDR_W-1:0] wR,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsvR,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              hazard
);

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic                w_wr_en;
  logic                w_rsv_en;
  logic [NUM_REGS-1:0] w_busy;
  logic [ADDR_W:0]     w_cnt;
  logic [DATA_W:0]     w_port_a;
  logic [DATA_W:0]     w_port_b;

  // Drop writes and reservations aimed at a hardwired zero register.
  always_comb begin
    if (ZERO_REG && (wR == '0)) begin
      w_wr_en = 1'b0;
    end else begin
      w_wr_en = write;
    end
    if (ZERO_REG && (rsvR == '0)) begin
      w_rsv_en = 1'b0;
    end else begin
      w_rsv_en = rsv;
    end
  end

  // Data array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[wR] <= dataIn;
    end
  end

  sb_tracker #(
    .NUM_REGS (NUM_REGS)
  ) u_sb_tracker (
    .clk       (clk),
    .rst_n     (reset),
    .i_set_en  (w_rsv_en),
    .i_set_idx (rsvR),
    .i_clr_en  (w_wr_en),
    .i_clr_idx (wR),
    .o_busy    (w_busy),
    .o_cnt     (w_cnt)
  );

  // One read port: returns {busy, data}. Forwarded write data also forwards
  // the busy clear, unless the same register is re-reserved this cycle, in
  // which case the registered busy bit is shown. Reset forces zero so that a
  // write presented during reset cannot leak through the bypass.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] i_addr);
    logic            w_hit_wr;
    logic            w_hit_rsv;
    logic [DATA_W:0] w_res;
    w_hit_wr  = BYPASS && w_wr_en && (wR == i_addr);
    w_hit_rsv = w_rsv_en && (rsvR == i_addr);
    if (!reset) begin
      w_res = '0;
    end else if (ZERO_REG && (i_addr == '0)) begin
      w_res = '0;
    end else if (w_hit_wr) begin
      w_res = {w_hit_rsv & w_busy[i_addr], dataIn};
    end else begin
      w_res = {w_busy[i_addr], r_mem[i_addr]};
    end
    return w_res;
  endfunction

  // Read port A.
  always_comb begin
    w_port_a = read_port(opA);
  end

  // Read port B.
  always_comb begin
    w_port_b = read_port(opB);
  end

  assign operand_a = w_port_a[DATA_W-1:0];
  assign busy_a    = w_port_a[DATA_W];
  assign operand_b = w_port_b[DATA_W-1:0];
  assign busy_b    = w_port_b[DATA_W];
  assign busy_cnt  = w_cnt;
  assign hazard    = busy_a | busy_b;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Two instances driven from shared stimulus:
//   u_dut0 : DATA_W=8,  NUM_REGS=8,  ZERO_REG=0, BYPASS=1 (low address/data bits)
//   u_dut1 : DATA_W=16, NUM_REGS=16, ZERO_REG=1, BYPASS=0
// Each is compared against an array-based reference model every cycle.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opA, opB, wR, rsvR;
  logic        write, rsv;
  logic [15:0] dataIn;

  logic [7:0]  a0, b0;
  logic        ba0, bb0, hz0;
  logic [3:0]  cnt0;
  logic [15:0] a1, b1;
  logic        ba1, bb1, hz1;
  logic [4:0]  cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: [instance][register]
  logic [15:0] m_reg  [2][16];
  bit          m_busy [2][16];

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(8), .NUM_REGS(8), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .opA(opA[2:0]), .opB(opB[2:0]), .write(write),
    .wR(wR[2:0]), .dataIn(dataIn[7:0]), .rsv(rsv), .rsvR(rsvR[2:0]),
    .operand_a(a0), .operand_b(b0), .busy_a(ba0), .busy_b(bb0),
    .busy_cnt(cnt0), .hazard(hz0)
  );

  reg_file_sb #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .opA(opA), .opB(opB), .write(write),
    .wR(wR), .dataIn(dataIn), .rsv(rsv), .rsvR(rsvR),
    .operand_a(a1), .operand_b(b1), .busy_a(ba1), .busy_b(bb1),
    .busy_cnt(cnt1), .hazard(hz1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ad(int k, logic [3:0] a);
    return (k == 0) ? int'(a[2:0]) : int'(a);
  endfunction
  function automatic bit zr(int k);  return (k == 1); endfunction
  function automatic bit byp(int k); return (k == 0); endfunction
  function automatic int nr(int k);  return (k == 0) ? 8 : 16; endfunction
  function automatic logic [15:0] dm(int k);
    return (k == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic bit wr_ok(int k);
    return write && !(zr(k) && ad(k, wR) == 0);
  endfunction
  function automatic bit rsv_ok(int k);
    return rsv && !(zr(k) && ad(k, rsvR) == 0);
  endfunction

  function automatic logic [15:0] exp_op(int k, logic [3:0] a);
    int ai = ad(k, a);
    if (!reset) return 16'h0000;
    if (zr(k) && ai == 0) return 16'h0000;
    if (byp(k) && wr_ok(k) && ad(k, wR) == ai) return dataIn & dm(k);
    return m_reg[k][ai];
  endfunction

  function automatic logic exp_busy(int k, logic [3:0] a);
    int ai = ad(k, a);
    if (!reset) return 1'b0;
    if (byp(k) && wr_ok(k) && ad(k, wR) == ai && !(rsv_ok(k) && ad(k, rsvR) == ai))
      return 1'b0;
    return m_busy[k][ai];
  endfunction

  function automatic int exp_cnt(int k);
    int c = 0;
    if (!reset) return 0;
    for (int i = 0; i < nr(k); i++) c += int'(m_busy[k][i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        m_reg[k][i]  = 16'h0000;
        m_busy[k][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (wr_ok(k)) begin
        m_reg[k][ad(k, wR)]  = dataIn & dm(k);
        m_busy[k][ad(k, wR)] = 1'b0;
      end
      if (rsv_ok(k)) m_busy[k][ad(k, rsvR)] = 1'b1;
    end
  endtask

  task automatic check_model();
    check_eq("d0_operand_a", a0,   exp_op(0, opA));
    check_eq("d0_operand_b", b0,   exp_op(0, opB));
    check_eq("d0_busy_a",    ba0,  exp_busy(0, opA));
    check_eq("d0_busy_b",    bb0,  exp_busy(0, opB));
    check_eq("d0_hazard",    hz0,  exp_busy(0, opA) | exp_busy(0, opB));
    check_eq("d0_busy_cnt",  cnt0, exp_cnt(0));
    check_eq("d1_operand_a", a1,   exp_op(1, opA));
    check_eq("d1_operand_b", b1,   exp_op(1, opB));
    check_eq("d1_busy_a",    ba1,  exp_busy(1, opA));
    check_eq("d1_busy_b",    bb1,  exp_busy(1, opB));
    check_eq("d1_hazard",    hz1,  exp_busy(1, opA) | exp_busy(1, opB));
    check_eq("d1_busy_cnt",  cnt1, exp_cnt(1));
  endtask

  // Apply inputs at the falling edge, then check combinational outputs.
  task automatic drive(input logic rst, input logic [3:0] a, input logic [3:0] b,
                       input logic w, input logic [3:0] wr, input logic [15:0] d,
                       input logic r, input logic [3:0] rr);
    @(negedge clk);
    reset = rst; opA = a; opB = b; write = w; wR = wr; dataIn = d; rsv = r; rsvR = rr;
    #1;
    if (!reset) model_reset();
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
  endtask

  initial begin
    reset = 1'b0; opA = 4'd0; opB = 4'd0; write = 1'b0; wR = 4'd0;
    dataIn = 16'h0000; rsv = 1'b0; rsvR = 4'd0;
    model_reset();

    // reset held: writes/reserves must not appear, even through bypass
    drive(1'b0, 4'd3, 4'd3, 1'b1, 4'd3, 16'h1234, 1'b1, 4'd3);
    check_eq("rst_byp_a0", a0, 32'h0);
    tick();
    drive(1'b0, 4'd3, 4'd5, 1'b1, 4'd5, 16'h5678, 1'b1, 4'd5);
    tick();

    // 1: all registers zero and free after release
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 4'(15 - i), 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
      tick();
    end

    // 2: bypass vs no bypass
    drive(1'b1, 4'd3, 4'd0, 1'b1, 4'd3, 16'h000A, 1'b0, 4'd0);
    check_eq("t2_byp_a0",   a0, 32'h0A);
    check_eq("t2_nobyp_a1", a1, 32'h00);
    tick();
    drive(1'b1, 4'd3, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    check_eq("t2_after_a1", a1, 32'h0A);
    tick();

    // 3: reserve then complete r5
    drive(1'b1, 4'd0, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5);
    tick();
    drive(1'b1, 4'd0, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    check_eq("t3_bb0",  bb0,  32'h1);
    check_eq("t3_hz0",  hz0,  32'h1);
    check_eq("t3_cnt0", cnt0, 32'h1);
    tick();
    drive(1'b1, 4'd0, 4'd5, 1'b1, 4'd5, 16'h0055, 1'b0, 4'd0);
    check_eq("t3_byp_bb0",   bb0, 32'h0);
    check_eq("t3_byp_b0",    b0,  32'h55);
    check_eq("t3_nobyp_bb1", bb1, 32'h1);
    tick();
    drive(1'b1, 4'd0, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    check_eq("t3_cnt0_done", cnt0, 32'h0);
    check_eq("t3_b1_done",   b1,   32'h55);
    tick();

    // 4: same-cycle reserve and write, then repeat reserve
    drive(1'b1, 4'd2, 4'd2, 1'b1, 4'd2, 16'h00AA, 1'b1, 4'd2);
    tick();
    drive(1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2);
    check_eq("t4_a0",   a0,   32'hAA);
    check_eq("t4_ba0",  ba0,  32'h1);
    check_eq("t4_cnt0", cnt0, 32'h1);
    tick();
    drive(1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    check_eq("t4_cnt0_rep", cnt0, 32'h1);
    check_eq("t4_cnt1_rep", cnt1, 32'h1);
    tick();

    // 5: zero register on dut1, wide r15
    drive(1'b1, 4'd0, 4'd15, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0);
    tick();
    drive(1'b1, 4'd0, 4'd15, 1'b1, 4'd15, 16'hBEEF, 1'b0, 4'd0);
    check_eq("t5_a1_zero", a1,   32'h0);
    check_eq("t5_ba1",     ba1,  32'h0);
    check_eq("t5_cnt1",    cnt1, 32'h1);
    tick();
    drive(1'b1, 4'd0, 4'd15, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    check_eq("t5_b1_beef", b1, 32'hBEEF);
    check_eq("t5_b0_ef",   b0, 32'hEF);
    tick();

    // 6: reservations lost on asynchronous reset
    drive(1'b1, 4'd1, 4'd4, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd1); tick();
    drive(1'b1, 4'd1, 4'd4, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd4); tick();
    drive(1'b1, 4'd1, 4'd6, 1'b1, 4'd1, 16'h0011, 1'b1, 4'd6); tick();
    drive(1'b0, 4'd1, 4'd6, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    check_eq("t6_cnt0_rst", cnt0, 32'h0);
    check_eq("t6_cnt1_rst", cnt1, 32'h0);
    tick();
    drive(1'b1, 4'd1, 4'd6, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    check_eq("t6_a1_after", a1, 32'h0);
    tick();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] ra, rb, rw, rr;
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      rw = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) == 0) ? rw : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 79) != 0), ra, rb, 1'($urandom_range(0, 1)), rw,
            16'($urandom), ($urandom_range(0, 4) < 2), rr);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8x8 two-read/one-write register memory.
- Configurable data width and register count, optional hardwired zero register, and optional write-to-read bypass.
- Adds a per-register scoreboard of busy bits so the control unit can reserve a destination for an in-flight result and detect read-after-write hazards.
- Sits between decode (opA/opB/wR) and the ALU/writeback path of the processor.

Parameters:
DATA_W, 8, register data width in bits (>=1)
NUM_REGS, 8, number of registers; power of two, >=2
ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)
ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and reservations
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
opA  input  ADDR_W  read address, port A
opB  input  ADDR_W  read address, port B
write  input  1  write enable
wR  input  ADDR_W  write address
dataIn  input  DATA_W  write data
rsv  input  1  reserve request: mark register rsvR busy
rsvR  input  ADDR_W  register to reserve
operand_a  output  DATA_W  read data, port A
operand_b  output  DATA_W  read data, port B
busy_a  output  1  register opA has an outstanding reservation
busy_b  output  1  register opB has an outstanding reservation
busy_cnt  output  ADDR_W+1  number of busy registers
hazard  output  1  busy_a | busy_b

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, all busy bits = 0, busy_cnt = 0. While reset is low, every output is 0.
- Reset deassertion is synchronised by the parent. The first write is accepted at the first rising edge after reset goes high.
- Reads are combinational: operand_a = reg[opA], operand_b = reg[opB].
- Bypass (BYPASS=1): if write=1 and wR==opA, operand_a = dataIn in the same cycle. Port B behaves the same way.
- No bypass (BYPASS=0): reads show the old value until the edge.
- Write: at the rising edge with write=1, reg[wR] <= dataIn and busy[wR] <= 0.
- Reserve: at the rising edge with rsv=1, busy[rsvR] <= 1.
- Reserve and write to the same register in the same cycle: the reservation wins (busy stays 1 for the new producer) and the data is still written.
- Reserve of an already-busy register: no change; busy_cnt is not double-counted.
- Write to a non-busy register: allowed, data written, busy stays 0.
- busy_a/busy_b reflect the registered busy bits. With BYPASS=1, a write in the same cycle to opA/opB that is not simultaneously re-reserved clears busy_a/busy_b combinationally, consistent with the forwarded data.
- busy_cnt is a registered counter. Each cycle it adjusts as follows:
  - +1 for a reserve that sets a previously clear bit;
  - -1 for a write that clears a previously set bit;
  - both in one cycle on different registers: net 0.
  - It never exceeds NUM_REGS (or NUM_REGS-1 when ZERO_REG=1) and never underflows.
- ZERO_REG=1:
  - reg[0] reads 0 on both ports, including under bypass;
  - write to 0 is dropped;
  - rsv to 0 is dropped;
  - busy for register 0 is always 0.
- Both read ports may address the same register; both return identical data and busy.
- Reset asserted mid-operation clears data and scoreboard immediately. Pending reservations are lost; the control unit re-issues them.

Decomposition:
- Shared package regfile_pkg holds default DATA_W/NUM_REGS constants and the typedefs reg_addr_t and reg_data_t.
- One sub-module, sb_tracker, holds the busy-bit vector and busy_cnt: reserve/clear inputs, busy-vector and count outputs.
- The data array, read muxes and bypass stay in reg_file_sb.

Test Plan:
1. Reset with DATA_W=8, NUM_REGS=8: after release, every opA/opB from 0..7 -> operand 8'h00, busy 0, busy_cnt 0.
2. Write 8'h0A to r3 and in the same cycle read opA=3 -> operand_a=8'h0A combinationally (BYPASS=1). With BYPASS=0, operand_a=8'h00 until the edge, then 8'h0A.
3. rsv r5 -> busy_cnt=1; reading opB=5 gives busy_b=1 and hazard=1. Write 8'h55 to r5 -> busy_b=0, busy_cnt=0, operand_b=8'h55.
4. Same-cycle rsv r2 and write 8'hAA to r2 -> r2=8'hAA, busy[2]=1, busy_cnt=1. Then rsv r2 again -> busy_cnt still 1.
5. ZERO_REG=1: write 8'hFF to r0 and rsv r0 -> operand_a=8'h00, busy_a=0, busy_cnt=0. Repeat with DATA_W=16, NUM_REGS=16 and check r15 write/read of 16'hBEEF.
6. Reserve r1, r4, r6 (busy_cnt=3), then assert reset mid-cycle -> outputs 0 immediately without a clock edge, busy_cnt=0; after release, r1 reads 0.
